tt_mux_seq: RTL and testbench

Registered, parametrised row mux connecting one row of N_UM user modules to the vertical spine. It decodes the spine select field against the row address strap and routes the inward bus to exactly one module. It also returns that module's outputs to the spine. On a module change it enforces break-before-make: the old module is disabled and a programmable guard interval elapses before the new module is enabled. It sits between the spine and the user-module columns of each row.

---
 rtl/tt_mux_seq.sv | 148 ++++++++++++++
 tb/tb_tt_mux_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_mux_seq.sv
// tt_mux_seq: registered row mux between the vertical spine and one row of
// N_UM user modules. Decodes {row, col} from the spine, enables exactly one
// module, and enforces break-before-make with a GUARD_CYC-cycle drain
// interval whenever the selected module changes or is deselected.
module tt_mux_seq #(
   parameter  int N_UM      = 16,
   parameter  int N_IO      = 8,
   parameter  int N_O       = 8,
   parameter  int N_I       = 10,
   parameter  int ROW_W     = 5,
   parameter  int GUARD_CYC = 2,
   parameter  int OUT_REG   = 1,
   localparam int COL_W     = $clog2(N_UM),
   localparam int U_OW      = N_O + 2 * N_IO,
   localparam int U_IW      = N_I + N_IO
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ROW_W-1:0]         addr,
   input  logic [ROW_W+COL_W-1:0]   si_sel,
   input  logic                     si_ena,
   input  logic [U_IW-1:0]          si_usr,
   output logic [U_OW-1:0]          so_usr,
   input  logic [U_OW*N_UM-1:0]     um_ow,
   output logic [U_IW*N_UM-1:0]     um_iw,
   output logic [N_UM-1:0]          um_ena,
   output logic                     busy,
   output logic [COL_W-1:0]         cur_um
);

   // Parameter legality is enforced at elaboration time.
   if (GUARD_CYC < 1 || GUARD_CYC > 15) begin : g_bad_guard
      $error("tt_mux_seq: GUARD_CYC must be within 1..15");
   end
   if (N_UM < 2 || N_UM > 32 || (N_UM & (N_UM - 1)) != 0) begin : g_bad_num
      $error("tt_mux_seq: N_UM must be a power of two within 2..32");
   end

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;

   // Drain counter start value: DRAIN lasts exactly GUARD_CYC cycles.
   localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYC - 1);

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic [3:0]        gcnt_r;
   logic [3:0]        gcnt_nxt_s;
   logic [COL_W-1:0]  cur_um_r;
   logic [COL_W-1:0]  cur_nxt_s;
   logic [U_IW-1:0]   iw_q_r;

   logic              tgt_vld_s;
   logic [COL_W-1:0]  tgt_col_s;
   logic              active_s;
   logic [U_OW-1:0]   mux_ow_s;

   assign tgt_vld_s = si_ena && (si_sel[ROW_W+COL_W-1:COL_W] == addr);
   assign tgt_col_s = si_sel[COL_W-1:0];
   assign active_s  = (state_r == ST_ACTIVE);
   assign mux_ow_s  = um_ow[U_OW*cur_um_r +: U_OW];

   // Next-state decode: select, hold, drain and the latest-select-wins re-entry.
   always_comb begin
      state_nxt_s = state_r;
      gcnt_nxt_s  = gcnt_r;
      cur_nxt_s   = cur_um_r;
      case (state_r)
         ST_IDLE: begin
            if (tgt_vld_s) begin
               state_nxt_s = ST_ACTIVE;
               cur_nxt_s   = tgt_col_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (tgt_vld_s && (tgt_col_s == cur_um_r)) begin
               state_nxt_s = ST_ACTIVE;
            end else begin
               state_nxt_s = ST_DRAIN;
               gcnt_nxt_s  = GUARD_INIT;
            end
         end
         ST_DRAIN: begin
            // A same-col re-select does not shorten the guard interval.
            if (gcnt_r != 4'd0) begin
               state_nxt_s = ST_DRAIN;
               gcnt_nxt_s  = gcnt_r - 4'd1;
            end else if (tgt_vld_s) begin
               state_nxt_s = ST_ACTIVE;
               cur_nxt_s   = tgt_col_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            gcnt_nxt_s  = 4'd0;
            cur_nxt_s   = {COL_W{1'b0}};
         end
      endcase
   end

   // State, counter, latched column and inward data register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         gcnt_r   <= 4'd0;
         cur_um_r <= {COL_W{1'b0}};
         iw_q_r   <= {U_IW{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         gcnt_r   <= gcnt_nxt_s;
         cur_um_r <= cur_nxt_s;
         iw_q_r   <= si_usr;
      end
   end

   // Per-module enable and gated inward data; unselected modules see zero.
   for (genvar k = 0; k < N_UM; k++) begin : g_um
      assign um_ena[k]              = active_s && (cur_um_r == COL_W'(k));
      assign um_iw[U_IW*k +: U_IW]  = um_ena[k] ? iw_q_r : {U_IW{1'b0}};
   end

   // Outward path: optional register stage, always forced to zero outside ACTIVE.
   if (OUT_REG != 0) begin : g_oreg
      logic [U_OW-1:0] ow_q_r;

      // Capture the selected module's outputs only while ACTIVE.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            ow_q_r <= {U_OW{1'b0}};
         end else begin
            ow_q_r <= active_s ? mux_ow_s : {U_OW{1'b0}};
         end
      end

      assign so_usr = active_s ? ow_q_r : {U_OW{1'b0}};
   end else begin : g_ocomb
      assign so_usr = active_s ? mux_ow_s : {U_OW{1'b0}};
   end

   assign busy   = (state_r == ST_DRAIN);
   assign cur_um = cur_um_r;

endmodule

// File: tb/tb_tt_mux_seq.sv
// Scoreboard bench for tt_mux_seq: two instances share all stimulus,
// dut0 with GUARD_CYC=2/OUT_REG=1 and dut1 with GUARD_CYC=1/OUT_REG=0.
module tb_tt_mux_seq;

   localparam int N_UM = 16;
   localparam int U_OW = 24;
   localparam int U_IW = 18;
   localparam int SELW = 9;

   typedef struct {
      logic [15:0]  ena;
      logic [287:0] iw;
      logic [23:0]  so;
      logic         busy;
      logic [3:0]   cur;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [4:0]        addr;
   logic [SELW-1:0]   si_sel;
   logic              si_ena;
   logic [U_IW-1:0]   si_usr;
   logic [U_OW*N_UM-1:0] um_ow;

   logic [U_OW-1:0]      so0, so1;
   logic [U_IW*N_UM-1:0] iw0, iw1;
   logic [N_UM-1:0]      ena0, ena1;
   logic                 busy0, busy1;
   logic [3:0]           cur0, cur1;

   int n_checks = 0;
   int n_errors = 0;

   exp_t sb_q[$];

   // Reference model state, one slot per instance.
   logic [1:0]  m_st[2];
   logic [3:0]  m_gc[2];
   logic [3:0]  m_cur[2];
   logic [17:0] m_iw[2];
   logic [23:0] m_ow[2];

   always #5 clk = ~clk;

   tt_mux_seq #(.N_UM(16), .N_IO(8), .N_O(8), .N_I(10), .ROW_W(5),
                .GUARD_CYC(2), .OUT_REG(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .addr(addr), .si_sel(si_sel), .si_ena(si_ena),
      .si_usr(si_usr), .so_usr(so0), .um_ow(um_ow), .um_iw(iw0),
      .um_ena(ena0), .busy(busy0), .cur_um(cur0));

   tt_mux_seq #(.N_UM(16), .N_IO(8), .N_O(8), .N_I(10), .ROW_W(5),
                .GUARD_CYC(1), .OUT_REG(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .addr(addr), .si_sel(si_sel), .si_ena(si_ena),
      .si_usr(si_usr), .so_usr(so1), .um_ow(um_ow), .um_iw(iw1),
      .um_ena(ena1), .busy(busy1), .cur_um(cur1));

   task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance model instance i across one rising edge with the current inputs.
   task automatic model_update(input int i, input int g);
      logic       tv;
      logic [3:0] tc;
      tv = si_ena && (si_sel[8:4] == addr);
      tc = si_sel[3:0];
      if (!rst_n) begin
         m_st[i] = 2'd0; m_gc[i] = 4'd0; m_cur[i] = 4'd0;
         m_iw[i] = 18'd0; m_ow[i] = 24'd0;
      end else begin
         m_ow[i] = (m_st[i] == 2'd1) ? um_ow[24*m_cur[i] +: 24] : 24'd0;
         m_iw[i] = si_usr;
         case (m_st[i])
            2'd0: if (tv) begin m_st[i] = 2'd1; m_cur[i] = tc; end
            2'd1: if (!(tv && tc == m_cur[i])) begin m_st[i] = 2'd2; m_gc[i] = 4'(g - 1); end
            2'd2: begin
               if (m_gc[i] != 4'd0) m_gc[i] = m_gc[i] - 4'd1;
               else if (tv) begin m_st[i] = 2'd1; m_cur[i] = tc; end
               else m_st[i] = 2'd0;
            end
            default: m_st[i] = 2'd0;
         endcase
      end
   endtask

   function automatic exp_t model_out(input int i, input bit oreg);
      exp_t e;
      logic act;
      act    = (m_st[i] == 2'd1);
      e.ena  = act ? (16'd1 << m_cur[i]) : 16'd0;
      e.iw   = 288'd0;
      if (act) e.iw[18*m_cur[i] +: 18] = m_iw[i];
      e.so   = act ? (oreg ? m_ow[i] : um_ow[24*m_cur[i] +: 24]) : 24'd0;
      e.busy = (m_st[i] == 2'd2);
      e.cur  = m_cur[i];
      return e;
   endfunction

   // One clock: push expectations, take the edge, pop and compare both instances.
   task automatic step();
      exp_t e;
      model_update(0, 2);
      sb_q.push_back(model_out(0, 1'b1));
      model_update(1, 1);
      sb_q.push_back(model_out(1, 1'b0));
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("d0_ena", ena0, e.ena);   check("d0_iw", iw0, e.iw);
      check("d0_so", so0, e.so);      check("d0_busy", busy0, e.busy);
      check("d0_cur", cur0, e.cur);
      e = sb_q.pop_front();
      check("d1_ena", ena1, e.ena);   check("d1_iw", iw1, e.iw);
      check("d1_so", so1, e.so);      check("d1_busy", busy1, e.busy);
      check("d1_cur", cur1, e.cur);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [287:0] iw_exp;
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 2'd0; m_gc[i] = 4'd0; m_cur[i] = 4'd0; m_iw[i] = 18'd0; m_ow[i] = 24'd0;
      end
      for (int k = 0; k < N_UM; k++) um_ow[24*k +: 24] = 24'($urandom);
      um_ow[24*5 +: 24] = 24'hC3C3C3;
      addr   = 5'd3;
      si_usr = 18'h11111;
      @(negedge clk);

      // Reset held with a matching select active.
      rst_n = 1'b0; si_ena = 1'b1; si_sel = {5'd3, 4'd4};
      step(); step();
      check("rst_ena", ena0, 16'h0000);
      check("rst_busy", busy0, 1'b0);
      rst_n = 1'b1;
      step();
      check("rel_ena4", ena0, 16'h0010);

      // Deselect: ACTIVE -> DRAIN (2 cycles) -> IDLE.
      si_ena = 1'b0;
      step(); check("desel_busy", busy0, 1'b1);
      step(); step();
      check("desel_idle", busy0, 1'b0);

      // Row mismatch keeps everything off.
      si_ena = 1'b1; si_sel = {5'd4, 4'd5};
      step(); step();
      check("rowmis_ena", ena0, 16'h0000);
      check("rowmis_so", so0, 24'h000000);

      // Select col 5 with data.
      si_sel = {5'd3, 4'd5}; si_usr = 18'h2A5A5;
      step();
      iw_exp = 288'd0;
      iw_exp[18*5 +: 18] = 18'h2A5A5;
      check("sel5_ena", ena0, 16'h0020);
      check("sel5_iw", iw0, iw_exp);
      check("sel5_so_first", so0, 24'h000000);
      step();
      check("sel5_so", so0, 24'hC3C3C3);

      // Switch toward 9, replaced by 12 on the last DRAIN edge.
      si_sel = {5'd3, 4'd9};
      step(); check("sw_busy", busy0, 1'b1); check("sw_so", so0, 24'h000000);
      step(); check("sw_gap", ena0, 16'h0000);
      si_sel = {5'd3, 4'd12};
      step();
      check("late_ena12", ena0, 16'h1000);
      check("late_cur12", cur0, 4'd12);

      // Plain switch 12 -> 9 with a 2-cycle gap.
      si_sel = {5'd3, 4'd9};
      step(); check("sw9_gap1", ena0, 16'h0000);
      step(); check("sw9_gap2", ena0, 16'h0000);
      step(); check("sw9_ena", ena0, 16'h0200);

      // Reset in the middle of DRAIN.
      si_sel = {5'd3, 4'd3};
      step();
      rst_n = 1'b0;
      step();
      check("rstdr_busy", busy0, 1'b0);
      check("rstdr_cur", cur0, 4'd0);
      rst_n = 1'b1; si_ena = 1'b0;
      step();

      // Randomised traffic.
      for (int n = 0; n < 400; n++) begin
         rst_n  = ($urandom_range(0, 59) != 0);
         si_ena = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 3) == 0)
            si_sel[3:0] = 4'($urandom);
         si_sel[8:4] = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd3;
         si_usr = 18'($urandom);
         um_ow[24*$urandom_range(0, 15) +: 24] = 24'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
